s7_iserdes_align: RTL and testbench

//  Link-training controller for the 7-series ISERDES/IDELAY receive path of the LVDS ADC

---
 rtl/s7_iserdes_align.sv | 267 ++++++++++++++++++++++++++
 tb/tb_s7_iserdes_align.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/s7_iserdes_align.sv
// s7_iserdes_align
//   Link-training controller for a 7-series ISERDES/IDELAY receive lane.
//   It sweeps the IDELAY taps on the frame lane and finds the longest run of
//   taps that give stable deserialized words. It then parks the tap at the
//   centre of that run and pulses BITSLIP until the frame word matches
//   FRAME_PATTERN. Everything runs in the CLKDIV domain.
//
// Ports
//   sys_clk     in   CLKDIV-domain clock
//   sys_rst_n   in   async active-low reset (release synchronised internally)
//   start       in   1-cycle pulse, begins training (honoured in IDLE/DONE/FAIL)
//   frame_word  in   ISERDES parallel word of the frame lane
//   idelay_tap  out  IDELAY CNTVALUEIN, holds last loaded value
//   idelay_ld   out  1-cycle IDELAY LD strobe
//   bitslip     out  1-cycle ISERDES BITSLIP pulse
//   busy        out  training in progress
//   done        out  aligned, held until next start
//   fail        out  training failed, held until next start
//   win_len     out  length of chosen stable window (0..32)
//
// State table
//   IDLE      | waiting for start after reset
//   LOAD      | sweep: idelay_ld pulse for current tap
//   SETTLE    | sweep: let IDELAY settle
//   SAMPLE    | sweep: check N_SAMPLE words for stability, update window
//   CENTER    | pick centre of best window (or fail if none)
//   CLOAD     | idelay_ld pulse for centre tap
//   CSETTLE   | let IDELAY settle on centre tap
//   SLIP_CHK  | compare N_SAMPLE words against FRAME_PATTERN
//   SLIP      | bitslip pulse
//   SLIP_WAIT | let ISERDES settle after bitslip
//   DONE      | aligned
//   FAIL      | no window, or bitslip budget exhausted
module s7_iserdes_align #(
  parameter int              DW            = 8,
  parameter logic [DW-1:0]   FRAME_PATTERN = 8'hF0,
  parameter int              N_TAPS        = 32,
  parameter int              SETTLE        = 16,
  parameter int              N_SAMPLE      = 64,
  parameter int              SLIP_WAIT     = 4,
  parameter int              SLIP_MAX      = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          start,
  input  logic [DW-1:0] frame_word,
  output logic [4:0]    idelay_tap,
  output logic          idelay_ld,
  output logic          bitslip,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [5:0]    win_len
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_CENTER, S_CLOAD, S_CSETTLE,
    S_SLIP_CHK, S_SLIP, S_SLIP_WAIT, S_DONE, S_FAIL
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge, so the FSM
  // never starts up mid-cycle and no strobe can appear partially.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [4:0]    tap_q, tap_d;
  logic [DW-1:0] ref_q, ref_d;
  logic          bad_q, bad_d;
  logic [5:0]    cur_len_q, cur_len_d;
  logic [4:0]    cur_start_q, cur_start_d;
  logic [5:0]    best_len_q, best_len_d;
  logic [4:0]    best_start_q, best_start_d;
  logic [5:0]    win_len_q, win_len_d;
  logic [3:0]    slips_q, slips_d;

  logic          samp_stable;
  logic          pat_mism;
  logic [5:0]    len_inc;
  logic [4:0]    start_eff;

  always_ff @(posedge sys_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      ref_q        <= '0;
      bad_q        <= 1'b0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      win_len_q    <= '0;
      slips_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      ref_q        <= ref_d;
      bad_q        <= bad_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      win_len_q    <= win_len_d;
      slips_q      <= slips_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    ref_d        = ref_q;
    bad_d        = bad_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    win_len_d    = win_len_q;
    slips_d      = slips_q;

    // The last word of a sample run is judged combinationally so the
    // decision lands on the same edge as that word.
    samp_stable = !bad_q && (frame_word == ref_q);
    pat_mism    = (frame_word != FRAME_PATTERN);
    len_inc     = cur_len_q + 6'd1;
    start_eff   = (cur_len_q == 6'd0) ? tap_q : cur_start_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          tap_d        = '0;
          cur_len_d    = '0;
          cur_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
          win_len_d    = '0;
          slips_d      = '0;
          state_d      = S_LOAD;
        end
      end

      S_LOAD: begin
        cnt_d   = 8'(SETTLE - 1);
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'(N_SAMPLE - 1);
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_SAMPLE: begin
        if (cnt_q == 8'(N_SAMPLE - 1)) begin
          ref_d = frame_word;
          bad_d = 1'b0;
        end else if (frame_word != ref_q) begin
          bad_d = 1'b1;
        end
        if (cnt_q == 8'd0) begin
          if (samp_stable) begin
            cur_len_d   = len_inc;
            cur_start_d = start_eff;
            // Strict compare: on a tie the earlier window stays selected.
            if (len_inc > best_len_q) begin
              best_len_d   = len_inc;
              best_start_d = start_eff;
            end
          end else begin
            cur_len_d = '0;
          end
          if (tap_q == 5'(N_TAPS - 1)) begin
            state_d = S_CENTER;
          end else begin
            tap_d   = tap_q + 5'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_CENTER: begin
        if (best_len_q == 6'd0) begin
          state_d = S_FAIL;
        end else begin
          tap_d     = best_start_q + 5'((best_len_q - 6'd1) >> 1);
          win_len_d = best_len_q;
          slips_d   = '0;
          state_d   = S_CLOAD;
        end
      end

      S_CLOAD: begin
        cnt_d   = 8'(SETTLE - 1);
        state_d = S_CSETTLE;
      end

      S_CSETTLE: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'(N_SAMPLE - 1);
          bad_d   = 1'b0;
          state_d = S_SLIP_CHK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_SLIP_CHK: begin
        if (pat_mism) bad_d = 1'b1;
        if (cnt_q == 8'd0) begin
          if (bad_q || pat_mism) begin
            state_d = (slips_q == 4'(SLIP_MAX)) ? S_FAIL : S_SLIP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      S_SLIP: begin
        slips_d = slips_q + 4'd1;
        cnt_d   = 8'(SLIP_WAIT - 1);
        state_d = S_SLIP_WAIT;
      end

      S_SLIP_WAIT: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'(N_SAMPLE - 1);
          bad_d   = 1'b0;
          state_d = S_SLIP_CHK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded straight from the state register: each strobe state
  // lasts exactly one cycle, and LOAD/CLOAD never coincide with SLIP.
  assign idelay_tap = tap_q;
  assign idelay_ld  = (state_q == S_LOAD) || (state_q == S_CLOAD);
  assign bitslip    = (state_q == S_SLIP);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign done       = (state_q == S_DONE);
  assign fail       = (state_q == S_FAIL);
  assign win_len    = win_len_q;

endmodule

// File: tb/tb_s7_iserdes_align.sv
// Directed bench for s7_iserdes_align. A small lane model produces the frame
// word: taps flagged in stable_mask give a constant word (rotated left one
// bit per bitslip pulse), all other taps give a word that changes every cycle.
module tb_s7_iserdes_align;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_word = 8'h00;
  logic [4:0] idelay_tap;
  logic       idelay_ld;
  logic       bitslip;
  logic       busy;
  logic       done;
  logic       fail;
  logic [5:0] win_len;

  s7_iserdes_align dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .frame_word (frame_word),
    .idelay_tap (idelay_tap),
    .idelay_ld  (idelay_ld),
    .bitslip    (bitslip),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .win_len    (win_len)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // lane model state
  logic [31:0] stable_mask = 32'h0;
  logic [7:0]  cur_word    = 8'h00;
  logic [4:0]  model_tap   = 5'd0;
  int cyc       = 0;
  int ld_cnt    = 0;
  int slip_cnt  = 0;
  int both_cnt  = 0;
  int last_slip = -1;
  int min_gap   = 1000000;
  int first_ld_tap = -1;

  initial begin
    logic [7:0] w;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (idelay_ld && bitslip) both_cnt++;
      if (idelay_ld) begin
        if (ld_cnt == 0) first_ld_tap = int'(idelay_tap);
        ld_cnt++;
        model_tap = idelay_tap;
      end
      if (bitslip) begin
        slip_cnt++;
        if (last_slip >= 0 && (cyc - last_slip) < min_gap) min_gap = cyc - last_slip;
        last_slip = cyc;
        cur_word = {cur_word[6:0], cur_word[7]};
      end
      if (stable_mask[model_tap]) begin
        frame_word = cur_word;
      end else begin
        w = 8'($urandom);
        if (w == frame_word) w = ~w;
        frame_word = w;
      end
    end
  end

  task automatic setup(input logic [31:0] mask, input logic [7:0] base);
    stable_mask  = mask;
    cur_word     = base;
    ld_cnt       = 0;
    slip_cnt     = 0;
    both_cnt     = 0;
    last_slip    = -1;
    min_gap      = 1000000;
    first_ld_tap = -1;
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // Wait for done/fail; optionally pulse start mid-run while busy.
  task automatic wait_end(input bit poke, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge sys_clk);
      start = (poke && i == 500);
      if (done || fail) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    bit to;

    // ---- 1: reset values, async reset mid-SAMPLE ----
    #2;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_tap", int'(idelay_tap), 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    setup(32'hFFFF_FFFF, 8'hF0);
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (idelay_tap == 5'd3) begin
        to = 1'b0;
        break;
      end
    end
    check_eq("t1_reach_tap3_timeout", int'(to), 0);
    repeat (40) @(negedge sys_clk);
    check_eq("t1_busy_before_rst", int'(busy), 1);
    check_eq("t1_tap_before_rst", int'(idelay_tap), 3);
    #3 sys_rst_n = 1'b0;
    #1;
    check_eq("t1_rst_busy", int'(busy), 0);
    check_eq("t1_rst_done", int'(done), 0);
    check_eq("t1_rst_fail", int'(fail), 0);
    check_eq("t1_rst_ld", int'(idelay_ld), 0);
    check_eq("t1_rst_bitslip", int'(bitslip), 0);
    check_eq("t1_rst_tap", int'(idelay_tap), 0);
    check_eq("t1_rst_winlen", int'(win_len), 0);
    repeat (2) @(negedge sys_clk);
    ld_cnt = 0;
    slip_cnt = 0;
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    check_eq("t1_idle_busy", int'(busy), 0);
    check_eq("t1_idle_tap", int'(idelay_tap), 0);
    check_eq("t1_idle_no_ld", ld_cnt, 0);
    check_eq("t1_idle_no_slip", slip_cnt, 0);

    // ---- 2: window 10..19, frame already aligned ----
    setup(32'h000F_FC00, 8'hF0);
    pulse_start();
    wait_end(1'b0, to);
    check_eq("t2_timeout", int'(to), 0);
    repeat (2) @(negedge sys_clk);
    check_eq("t2_done", int'(done), 1);
    check_eq("t2_fail", int'(fail), 0);
    check_eq("t2_busy", int'(busy), 0);
    check_eq("t2_tap", int'(idelay_tap), 14);
    check_eq("t2_winlen", int'(win_len), 10);
    check_eq("t2_ld_pulses", ld_cnt, 33);
    check_eq("t2_slips", slip_cnt, 0);
    check_eq("t2_ld_and_slip", both_cnt, 0);

    // ---- 3: two equal windows, earlier one wins ----
    setup(32'h01F0_00F8, 8'hF0);
    pulse_start();
    wait_end(1'b0, to);
    check_eq("t3_timeout", int'(to), 0);
    check_eq("t3_done", int'(done), 1);
    check_eq("t3_tap", int'(idelay_tap), 5);
    check_eq("t3_winlen", int'(win_len), 5);

    // ---- 4: full window, 3 bitslips from 8'h1E ----
    setup(32'hFFFF_FFFF, 8'h1E);
    pulse_start();
    wait_end(1'b0, to);
    check_eq("t4_timeout", int'(to), 0);
    check_eq("t4_done", int'(done), 1);
    check_eq("t4_fail", int'(fail), 0);
    check_eq("t4_tap", int'(idelay_tap), 15);
    check_eq("t4_winlen", int'(win_len), 32);
    check_eq("t4_slips", slip_cnt, 3);
    check_eq("t4_ld_and_slip", both_cnt, 0);

    // ---- 5: no stable tap ----
    setup(32'h0000_0000, 8'hF0);
    pulse_start();
    wait_end(1'b0, to);
    check_eq("t5_timeout", int'(to), 0);
    check_eq("t5_fail", int'(fail), 1);
    check_eq("t5_done", int'(done), 0);
    check_eq("t5_winlen", int'(win_len), 0);
    check_eq("t5_slips", slip_cnt, 0);
    check_eq("t5_ld_pulses", ld_cnt, 32);
    check_eq("t5_tap_held", int'(idelay_tap), 31);

    // ---- 6: pattern never matches, start while busy ignored ----
    setup(32'h0000_FF00, 8'h00);
    pulse_start();
    wait_end(1'b1, to);
    check_eq("t6_timeout", int'(to), 0);
    repeat (3) @(negedge sys_clk);
    check_eq("t6_fail", int'(fail), 1);
    check_eq("t6_done", int'(done), 0);
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_slips", slip_cnt, 8);
    check_eq("t6_slip_gap_ok", int'(min_gap >= 68), 1);
    check_eq("t6_ld_pulses", ld_cnt, 33);
    check_eq("t6_tap", int'(idelay_tap), 11);
    check_eq("t6_winlen", int'(win_len), 8);

    setup(32'h0000_FF00, 8'h00);
    pulse_start();
    @(negedge sys_clk);
    check_eq("t6_restart_ld_seen", ld_cnt, 1);
    check_eq("t6_restart_tap", first_ld_tap, 0);
    check_eq("t6_restart_busy", int'(busy), 1);
    check_eq("t6_restart_fail_clr", int'(fail), 0);
    check_eq("t6_restart_winlen_clr", int'(win_len), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
